// File: rtl/pu_load_sched.sv
// Load scheduler for one img2col PU: streams pixel pairs into the PU register file,
// fires the PU once per round and waits for its completion flag.
module pu_load_sched #(
    parameter int DATA_W  = 16,
    parameter int K       = 5,
    parameter int ADRS_W  = 5,
    parameter int ROUND_W = 6
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               cfg_start,
    input  logic [ROUND_W-1:0] cfg_rounds,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_data1,
    input  logic [DATA_W-1:0]  s_data2,
    output logic               pu_wr,
    output logic [ADRS_W-1:0]  pu_adrs1,
    output logic [ADRS_W-1:0]  pu_adrs2,
    output logic [DATA_W-1:0]  pu_new1,
    output logic [DATA_W-1:0]  pu_new2,
    output logic               pu_start,
    output logic [ROUND_W-1:0] pu_round,
    input  logic               pu_done,
    output logic               busy,
    output logic               done,
    output logic [2:0]         dbg_state
);
    // Stream handshake: a beat transfers on a rising clk edge where s_valid && s_ready;
    // s_valid may rise or fall freely, s_ready depends only on registered state.

    localparam int WIN    = K * K;
    localparam int BEATS0 = (WIN + 1) / 2;
    localparam int BEATSN = (K + 1) / 2;
    localparam int BASEN  = WIN - K;
    localparam int BEAT_W = $clog2(BEATS0 + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_FIRE = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [ROUND_W-1:0] rounds_q, rounds_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               last_q, last_d;
    logic               wr_q, wr_d;
    logic [ADRS_W-1:0]  adrs1_q, adrs1_d, adrs2_q, adrs2_d;
    logic [DATA_W-1:0]  new1_q, new1_d, new2_q, new2_d;

    logic               first_round;
    logic [BEAT_W-1:0]  beats_in_round;
    logic               odd_words;
    logic               last_beat;
    logic [ADRS_W-1:0]  base_adrs;
    logic [ADRS_W-1:0]  beat_adrs;

    always_comb begin
        first_round    = (round_q == '0);
        beats_in_round = first_round ? BEAT_W'(BEATS0) : BEAT_W'(BEATSN);
        odd_words      = first_round ? (WIN % 2 == 1) : (K % 2 == 1);
        last_beat      = (beat_q == beats_in_round - BEAT_W'(1));
        base_adrs      = first_round ? '0 : ADRS_W'(BASEN);
        beat_adrs      = base_adrs + (ADRS_W'(beat_q) << 1);
    end

    always_comb begin
        state_d  = state_q;
        rounds_d = rounds_q;
        round_d  = round_q;
        beat_d   = beat_q;
        last_d   = last_q;
        wr_d     = 1'b0;
        adrs1_d  = adrs1_q;
        adrs2_d  = adrs2_q;
        new1_d   = new1_q;
        new2_d   = new2_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    rounds_d = (cfg_rounds == '0) ? ROUND_W'(1) : cfg_rounds;
                    round_d  = '0;
                    beat_d   = '0;
                    last_d   = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                // last_q marks the cycle carrying the final write; FIRE follows it.
                if (last_q) begin
                    state_d = S_FIRE;
                end else if (s_valid) begin
                    wr_d    = 1'b1;
                    adrs1_d = beat_adrs;
                    new1_d  = s_data1;
                    // An odd final beat repeats port 1 on port 2 so no stray word is written.
                    adrs2_d = (last_beat && odd_words) ? beat_adrs : beat_adrs + ADRS_W'(1);
                    new2_d  = (last_beat && odd_words) ? s_data1 : s_data2;
                    beat_d  = beat_q + BEAT_W'(1);
                    last_d  = last_beat;
                end
            end
            S_FIRE: state_d = S_WAIT;
            S_WAIT: begin
                if (pu_done) begin
                    if (round_q == rounds_q - ROUND_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                        beat_d  = '0;
                        last_d  = 1'b0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            rounds_q <= '0;
            round_q  <= '0;
            beat_q   <= '0;
            last_q   <= 1'b0;
            wr_q     <= 1'b0;
            adrs1_q  <= '0;
            adrs2_q  <= '0;
            new1_q   <= '0;
            new2_q   <= '0;
        end else begin
            state_q  <= state_d;
            rounds_q <= rounds_d;
            round_q  <= round_d;
            beat_q   <= beat_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            adrs1_q  <= adrs1_d;
            adrs2_q  <= adrs2_d;
            new1_q   <= new1_d;
            new2_q   <= new2_d;
        end
    end

    always_comb begin
        s_ready   = (state_q == S_LOAD) && !last_q;
        pu_wr     = wr_q;
        pu_adrs1  = adrs1_q;
        pu_adrs2  = adrs2_q;
        pu_new1   = new1_q;
        pu_new2   = new2_q;
        pu_start  = (state_q == S_FIRE);
        pu_round  = round_q;
        busy      = (state_q == S_LOAD) || (state_q == S_FIRE) || (state_q == S_WAIT);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_pu_load_sched.sv
// Directed bench for pu_load_sched: whole jobs are driven beat by beat and every
// PU write is compared against an expected-write queue built from the stimulus.
module tb_pu_load_sched;
    localparam int DATA_W  = 16;
    localparam int K       = 5;
    localparam int ADRS_W  = 5;
    localparam int ROUND_W = 6;
    localparam int WORD_W  = 2 * ADRS_W + 2 * DATA_W;

    logic               clk = 1'b0;
    logic               nrst = 1'b0;
    logic               cfg_start = 1'b0;
    logic [ROUND_W-1:0] cfg_rounds = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data1 = '0;
    logic [DATA_W-1:0]  s_data2 = '0;
    logic               pu_wr;
    logic [ADRS_W-1:0]  pu_adrs1, pu_adrs2;
    logic [DATA_W-1:0]  pu_new1, pu_new2;
    logic               pu_start;
    logic [ROUND_W-1:0] pu_round;
    logic               pu_done = 1'b0;
    logic               busy, done;
    logic [2:0]         dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] last_word = '0;

    pu_load_sched #(.DATA_W(DATA_W), .K(K), .ADRS_W(ADRS_W), .ROUND_W(ROUND_W)) dut (
        .clk(clk), .nrst(nrst), .cfg_start(cfg_start), .cfg_rounds(cfg_rounds),
        .s_valid(s_valid), .s_ready(s_ready), .s_data1(s_data1), .s_data2(s_data2),
        .pu_wr(pu_wr), .pu_adrs1(pu_adrs1), .pu_adrs2(pu_adrs2),
        .pu_new1(pu_new1), .pu_new2(pu_new2), .pu_start(pu_start), .pu_round(pu_round),
        .pu_done(pu_done), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one job end to end; inputs change on negedges, outputs are sampled there too.
    task automatic run_job(input logic [ROUND_W-1:0] cfg, input int exp_rounds,
                           input bit toggle, input int wait_cyc, input bit poke,
                           input logic [DATA_W-1:0] salt, input string tag);
        int sent, nb, base, starts;
        bit fin, v, exp_wr;
        logic [4:0] got_c, want_c;
        logic [ADRS_W-1:0] a1, a2;
        logic [DATA_W-1:0] d1, d2;
        logic [WORD_W-1:0] got_w;
        starts = 0;
        @(negedge clk);
        n_checks++;
        if ({busy, s_ready, pu_start, done, pu_wr} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s idle_ctrl: got %b want 00000", tag, {busy, s_ready, pu_start, done, pu_wr});
        end
        cfg_rounds = cfg;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int r = 0; r < exp_rounds; r++) begin
            nb = (r == 0) ? 13 : 3;
            base = (r == 0) ? 0 : 20;
            sent = 0;
            exp_wr = 1'b0;
            fin = 1'b0;
            for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
                got_c  = {busy, s_ready, pu_start, done, pu_wr};
                want_c = {1'b1, (sent < nb), 1'b0, 1'b0, exp_wr};
                n_checks++;
                if (got_c !== want_c) begin
                    n_fail++;
                    $display("FAIL %s load_ctrl r%0d c%0d: got %b want %b", tag, r, cyc, got_c, want_c);
                end
                n_checks++;
                if (pu_round !== ROUND_W'(r)) begin
                    n_fail++;
                    $display("FAIL %s load_round: got %0d want %0d", tag, pu_round, r);
                end
                if (exp_wr) begin
                    last_word = exp_q.pop_front();
                    if (sent == nb) fin = 1'b1;
                end
                got_w = {pu_adrs1, pu_adrs2, pu_new1, pu_new2};
                n_checks++;
                if (got_w !== last_word) begin
                    n_fail++;
                    $display("FAIL %s wr_word r%0d c%0d: got a=%0d,%0d d=%h,%h want a=%0d,%0d d=%h,%h",
                             tag, r, cyc, pu_adrs1, pu_adrs2, pu_new1, pu_new2,
                             last_word[WORD_W-1 -: ADRS_W], last_word[2*DATA_W +: ADRS_W],
                             last_word[DATA_W +: DATA_W], last_word[0 +: DATA_W]);
                end
                if (!fin) begin
                    v = (sent < nb) && (!toggle || (cyc % 2 == 0));
                    d1 = DATA_W'(salt + r * 64 + 2 * sent);
                    d2 = d1 + DATA_W'(1);
                    s_valid = v;
                    s_data1 = v ? d1 : 16'hDEAD;
                    s_data2 = v ? d2 : 16'hBEEF;
                    pu_done = poke && (cyc == 1);
                    if (v) begin
                        a1 = ADRS_W'(base + 2 * sent);
                        // Window and column sizes are odd, so the final beat duplicates port 1.
                        a2 = (sent == nb - 1) ? a1 : a1 + ADRS_W'(1);
                        exp_q.push_back({a1, a2, d1, (sent == nb - 1) ? d1 : d2});
                        sent++;
                    end
                    exp_wr = v;
                    @(negedge clk);
                end
            end
            s_valid = 1'b0;
            pu_done = 1'b0;
            if (!fin) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s load_timeout r%0d: got %0d beats want %0d", tag, r, sent, nb);
                return;
            end
            @(negedge clk);
            got_c = {busy, s_ready, pu_start, done, pu_wr};
            n_checks++;
            if (got_c !== 5'b10100 || pu_round !== ROUND_W'(r)) begin
                n_fail++;
                $display("FAIL %s fire r%0d: got ctrl %b round %0d want 10100 round %0d", tag, r, got_c, pu_round, r);
            end
            if (pu_start) starts++;
            @(negedge clk);
            for (int i = 0; i <= wait_cyc; i++) begin
                got_c = {busy, s_ready, pu_start, done, pu_wr};
                n_checks++;
                if (got_c !== 5'b10000) begin
                    n_fail++;
                    $display("FAIL %s wait_ctrl r%0d: got %b want 10000", tag, r, got_c);
                end
                cfg_start = poke && (i == 0);
                pu_done   = (i == wait_cyc);
                @(negedge clk);
            end
            cfg_start = 1'b0;
            pu_done   = 1'b0;
        end
        got_c = {busy, s_ready, pu_start, done, pu_wr};
        n_checks++;
        if (got_c !== 5'b00010) begin
            n_fail++;
            $display("FAIL %s done_ctrl: got %b want 00010", tag, got_c);
        end
        @(negedge clk);
        got_c = {busy, s_ready, pu_start, done, pu_wr};
        n_checks++;
        if (got_c !== 5'b00000) begin
            n_fail++;
            $display("FAIL %s back_idle: got %b want 00000", tag, got_c);
        end
        n_checks++;
        if (starts != exp_rounds || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s job_totals: got starts=%0d pending=%0d want starts=%0d pending=0",
                     tag, starts, exp_q.size(), exp_rounds);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        #12;
        n_checks++;
        if ({busy, s_ready, pu_start, done, pu_wr, pu_adrs1, pu_adrs2, pu_new1, pu_new2, pu_round} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b rdy=%b wr=%b a1=%0d n1=%h round=%0d want all 0",
                     busy, s_ready, pu_wr, pu_adrs1, pu_new1, pu_round);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_single_round();
        run_job(6'd1, 1, 1'b0, 1, 1'b0, 16'h0000, "single");
    endtask

    task automatic test_multi_round();
        run_job(6'd3, 3, 1'b0, 0, 1'b0, 16'h1000, "multi");
    endtask

    task automatic test_valid_toggle();
        run_job(6'd2, 2, 1'b1, 3, 1'b0, 16'h2000, "toggle");
    endtask

    task automatic test_rounds_zero_and_ignored_inputs();
        run_job(6'd0, 1, 1'b0, 2, 1'b1, 16'h3000, "zero");
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        cfg_rounds = 6'd2;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int n = 0; n < 6; n++) begin
            s_valid = 1'b1;
            s_data1 = DATA_W'(16'h0100 + 2 * n);
            s_data2 = DATA_W'(16'h0101 + 2 * n);
            @(negedge clk);
        end
        n_checks++;
        if (pu_wr !== 1'b1 || pu_adrs1 !== 5'd10 || pu_new1 !== 16'h010a) begin
            n_fail++;
            $display("FAIL midload_pre: got wr=%b a1=%0d n1=%h want wr=1 a1=10 n1=010a", pu_wr, pu_adrs1, pu_new1);
        end
        #2;
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({busy, s_ready, pu_start, done, pu_wr, pu_adrs1, pu_adrs2, pu_new1, pu_new2, pu_round} !== '0) begin
            n_fail++;
            $display("FAIL midload_reset: got busy=%b rdy=%b wr=%b a1=%0d a2=%0d n1=%h want all 0",
                     busy, s_ready, pu_wr, pu_adrs1, pu_adrs2, pu_new1);
        end
        s_valid = 1'b0;
        exp_q.delete();
        last_word = '0;
        @(negedge clk);
        nrst = 1'b1;
        run_job(6'd1, 1, 1'b0, 1, 1'b0, 16'h4000, "restart");
    endtask

    initial begin
        test_reset();
        test_single_round();
        test_multi_round();
        test_valid_toggle();
        test_rounds_zero_and_ignored_inputs();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
